// File: rtl/ulpi_reg_write.sv
// ulpi_reg_write -- link-side ULPI register write engine.
//
// Issues an immediate register-write TX CMD, then the data byte, then STP.
// A PHY abort (dir rising while the link is transmitting) drops the bus,
// waits for dir to fall, and retries the whole write from the TX CMD. If nxt
// stays low for TIMEOUT_CYCLES cycles on any byte, the write is abandoned
// with STP and an error pulse.
//
// Optional feature macro: ULPI_EXT_REG_EN
//   defined   : reg_addr_i is 8 bits. Addresses above 8'h3F, or equal to 8'h2F,
//               use the extended form: TX CMD 8'hAF, then an address byte, then data.
//   undefined : reg_addr_i is 6 bits and the immediate form is always used.
//
// Parameters:
//   TIMEOUT_CYCLES   max cycles spent waiting for nxt on one byte
//
// Ports:
//   clk_i              ULPI 60 MHz clock, the only clock
//   rst_i              asynchronous active-high reset
//   reg_addr_i         register address (6 or 8 bits), stable while requested
//   reg_data_i         register write data, stable while requested
//   reg_write_en_i     level request, held until reg_write_done_o
//   reg_write_done_o   one-cycle pulse when the write ends (success or timeout)
//   reg_write_err_o    one-cycle pulse together with done on timeout
//   busy_o             high whenever the engine is not idle
//   ulpi_dir_i         PHY direction (1 = PHY drives the bus)
//   ulpi_nxt_i         PHY throttle; a byte is accepted in a cycle with nxt=1
//   ulpi_data_out_o    value the link drives onto the bus
//   ulpi_data_oe_o     link bus drive enable
//   ulpi_stp_o         ULPI stop
module ulpi_reg_write #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
`ifdef ULPI_EXT_REG_EN
  input  logic [7:0] reg_addr_i,
`else
  input  logic [5:0] reg_addr_i,
`endif
  input  logic [7:0] reg_data_i,
  input  logic       reg_write_en_i,
  output logic       reg_write_done_o,
  output logic       reg_write_err_o,
  output logic       busy_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic [7:0] ulpi_data_out_o,
  output logic       ulpi_data_oe_o,
  output logic       ulpi_stp_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TXCMD,
`ifdef ULPI_EXT_REG_EN
    S_EXTADDR,
`endif
    S_DATA,
    S_STP,
    S_ABORT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q;
  logic             tmo_err_d;
  logic             tmo_hit;
  logic [7:0]       txcmd_byte;

  logic [7:0] data_d;
  logic       oe_d, stp_d, done_d, err_d, busy_d;

`ifdef ULPI_EXT_REG_EN
  logic ext_form;
  // 8'h2F is the escape code for extended access, so it can never be sent
  // as an immediate address.
  assign ext_form   = (reg_addr_i > 8'h3F) || (reg_addr_i == 8'h2F);
  assign txcmd_byte = ext_form ? 8'hAF : {2'b10, reg_addr_i[5:0]};
`else
  assign txcmd_byte = {2'b10, reg_addr_i};
`endif

  // Last waiting cycle on the current byte: nxt still low and budget spent.
  assign tmo_hit = (cnt_q == CNT_LAST) && !ulpi_nxt_i;

  // State register, timeout counter and turnaround tracker.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= ulpi_dir_i;
    end
  end

  // Next-state logic. dir is checked before nxt: a PHY that turns the bus
  // around while asserting nxt has not accepted our byte.
  always_comb begin
    state_d   = state_q;
    tmo_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Both current and previous dir low: the turnaround cycle is over.
        if (reg_write_en_i && !ulpi_dir_i && !dir_q) state_d = S_TXCMD;
      end
      S_TXCMD: begin
        if (ulpi_dir_i) state_d = S_ABORT;
        else if (ulpi_nxt_i) begin
`ifdef ULPI_EXT_REG_EN
          state_d = ext_form ? S_EXTADDR : S_DATA;
`else
          state_d = S_DATA;
`endif
        end else if (tmo_hit) begin
          state_d   = S_STP;
          tmo_err_d = 1'b1;
        end
      end
`ifdef ULPI_EXT_REG_EN
      S_EXTADDR: begin
        if (ulpi_dir_i) state_d = S_ABORT;
        else if (ulpi_nxt_i) state_d = S_DATA;
        else if (tmo_hit) begin
          state_d   = S_STP;
          tmo_err_d = 1'b1;
        end
      end
`endif
      S_DATA: begin
        if (ulpi_dir_i) state_d = S_ABORT;
        else if (ulpi_nxt_i) state_d = S_STP;
        else if (tmo_hit) begin
          state_d   = S_STP;
          tmo_err_d = 1'b1;
        end
      end
      S_STP:   state_d = S_IDLE;
      S_ABORT: if (!ulpi_dir_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Counter restarts on every state change (including aborts) and only
    // advances while a byte is waiting for nxt.
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if ((state_q == S_TXCMD) || (state_q == S_DATA)
`ifdef ULPI_EXT_REG_EN
             || (state_q == S_EXTADDR)
`endif
            ) begin
      if (!ulpi_nxt_i) cnt_d = cnt_q + 1'b1;
    end
  end

  // Output logic, decoded from the next state so every output is registered
  // yet lines up with the state it belongs to.
  always_comb begin
    data_d = 8'h00;
    oe_d   = 1'b0;
    stp_d  = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_TXCMD: begin
        oe_d   = 1'b1;
        data_d = txcmd_byte;
      end
`ifdef ULPI_EXT_REG_EN
      S_EXTADDR: begin
        oe_d   = 1'b1;
        data_d = reg_addr_i;
      end
`endif
      S_DATA: begin
        oe_d   = 1'b1;
        data_d = reg_data_i;
      end
      S_STP: begin
        oe_d   = 1'b1;
        stp_d  = 1'b1;
        done_d = 1'b1;
        err_d  = tmo_err_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ulpi_data_out_o  <= 8'h00;
      ulpi_data_oe_o   <= 1'b0;
      ulpi_stp_o       <= 1'b0;
      reg_write_done_o <= 1'b0;
      reg_write_err_o  <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      ulpi_data_out_o  <= data_d;
      ulpi_data_oe_o   <= oe_d;
      ulpi_stp_o       <= stp_d;
      reg_write_done_o <= done_d;
      reg_write_err_o  <= err_d;
      busy_o           <= busy_d;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_write.sv
// Testbench for ulpi_reg_write (TIMEOUT_CYCLES = 16).
// Bytes the PHY model accepts (and the STP byte) are collected as {stp, data}
// entries and checked against an expected queue filled before each write.
module tb_ulpi_reg_write;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] reg_data = 8'h00;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       nxt = 1'b0;
  logic       done, err, busy, oe, stp;
  logic [7:0] dout;

  int n_cmp = 0;
  int n_mis = 0;

  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  always #5 clk = ~clk;

  ulpi_reg_write #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
`ifdef ULPI_EXT_REG_EN
    .reg_addr_i       (reg_addr),
`else
    .reg_addr_i       (reg_addr[5:0]),
`endif
    .reg_data_i       (reg_data),
    .reg_write_en_i   (en),
    .reg_write_done_o (done),
    .reg_write_err_o  (err),
    .busy_o           (busy),
    .ulpi_dir_i       (dir),
    .ulpi_nxt_i       (nxt),
    .ulpi_data_out_o  (dout),
    .ulpi_data_oe_o   (oe),
    .ulpi_stp_o       (stp)
  );

  // PHY model for one write. Stalls nxt for stall_tx cycles on the first
  // byte, optionally raises dir for abort_len cycles once the data byte is
  // on the bus, or never asserts nxt. Records what it accepts in obs_q.
  task automatic drive_write(input logic [7:0] addr, input logic [7:0] data,
                             input int stall_tx, input int abort_len, input bit nxt_never,
                             output int dones, output int errs, output int busy_cyc,
                             output int extra_busy, output bit oe_after_abort, output bit hung);
    int stall_cnt = 0;
    int accepted = 0;
    int dir_left = 0;
    bit aborted = 1'b0;
    bit check_next = 1'b0;
    bit fin = 1'b0;
    dones = 0; errs = 0; busy_cyc = 0; extra_busy = 0;
    oe_after_abort = 1'b1; hung = 1'b1;
    reg_addr = addr; reg_data = data; en = 1'b1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      if (check_next) begin
        oe_after_abort = oe;
        check_next = 1'b0;
      end
      if (done) begin
        dones++;
        if (err) errs++;
      end
      if (oe && !stp) busy_cyc++;
      if (stp) obs_q.push_back({1'b1, dout});
      dir = 1'b0;
      nxt = 1'b0;
      if (dir_left > 0) begin
        dir = 1'b1;
        dir_left--;
      end else if (oe && !stp) begin
        if (abort_len > 0 && !aborted && accepted == 1) begin
          aborted = 1'b1;
          dir = 1'b1;
          dir_left = abort_len - 1;
          check_next = 1'b1;
        end else if (nxt_never) begin
          nxt = 1'b0;
        end else if (stall_cnt < stall_tx) begin
          stall_cnt++;
        end else begin
          nxt = 1'b1;
          accepted++;
          obs_q.push_back({1'b0, dout});
        end
      end
      if (done) begin
        en = 1'b0;
        hung = 1'b0;
        fin = 1'b1;
      end
    end
    en = 1'b0; dir = 1'b0; nxt = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done) extra_busy++;
    end
    $display("write addr=%h data=%h stall=%0d abort=%0d: dones=%0d errs=%0d bus_cycles=%0d",
             addr, data, stall_tx, abort_len, dones, errs, busy_cyc);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; dir = 1'b0; nxt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({oe, stp, busy, done, err} !== 5'b0) begin
      n_mis++;
      $display("FAIL reset_ctrl: got oe,stp,busy,done,err=%b, expected 00000", {oe, stp, busy, done, err});
    end
    n_cmp++;
    if (dout !== 8'h00) begin
      n_mis++;
      $display("FAIL reset_data: got %h, expected 00", dout);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || oe !== 1'b0) begin
      n_mis++;
      $display("FAIL idle_after_reset: got busy=%b oe=%b, expected 0 0", busy, oe);
    end
    $display("reset: oe=%b stp=%b busy=%b data=%h", oe, stp, busy, dout);
  endtask

  task automatic test_write(input string name, input logic [7:0] addr, input logic [7:0] data,
                            input int stall_tx, input int abort_len, input bit nxt_never,
                            input int exp_err, input int exp_busy);
    int dones, errs, busy_cyc, extra;
    bit oe_ab, hung;
    logic [8:0] e, o;
    drive_write(addr, data, stall_tx, abort_len, nxt_never, dones, errs, busy_cyc, extra, oe_ab, hung);
    n_cmp++;
    if (hung) begin
      n_mis++;
      $display("FAIL %s_hang: no done within 200 cycles, expected one", name);
    end
    n_cmp++;
    if (dones != 1) begin
      n_mis++;
      $display("FAIL %s_done: got %0d done pulses, expected 1", name, dones);
    end
    n_cmp++;
    if (errs != exp_err) begin
      n_mis++;
      $display("FAIL %s_err: got %0d err pulses, expected %0d", name, errs, exp_err);
    end
    n_cmp++;
    if (extra != 0) begin
      n_mis++;
      $display("FAIL %s_no_repeat: got %0d busy/done cycles after done, expected 0", name, extra);
    end
    if (exp_busy >= 0) begin
      n_cmp++;
      if (busy_cyc != exp_busy) begin
        n_mis++;
        $display("FAIL %s_bus_cycles: got %0d, expected %0d", name, busy_cyc, exp_busy);
      end
    end
    if (abort_len > 0) begin
      n_cmp++;
      if (oe_ab !== 1'b0) begin
        n_mis++;
        $display("FAIL %s_abort_oe: got oe=%b after dir rose, expected 0", name, oe_ab);
      end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_mis++;
      $display("FAIL %s_count: got %0d bytes, expected %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_mis++;
        $display("FAIL %s_byte: got stp=%b data=%h, expected stp=%b data=%h", name, o[8], o[7:0], e[8], e[7:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_basic;
    exp_q.push_back(9'h084); exp_q.push_back(9'h045); exp_q.push_back(9'h100);
    test_write("basic", 8'h04, 8'h45, 0, 0, 1'b0, 0, 2);
  endtask

  task automatic test_stall;
    exp_q.push_back(9'h084); exp_q.push_back(9'h045); exp_q.push_back(9'h100);
    test_write("stall", 8'h04, 8'h45, 3, 0, 1'b0, 0, 5);
  endtask

  task automatic test_abort;
    exp_q.push_back(9'h084); exp_q.push_back(9'h084);
    exp_q.push_back(9'h045); exp_q.push_back(9'h100);
    test_write("abort", 8'h04, 8'h45, 0, 5, 1'b0, 0, -1);
  endtask

  task automatic test_timeout;
    exp_q.push_back(9'h100);
    test_write("timeout", 8'h04, 8'h45, 0, 0, 1'b1, 1, 16);
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    reg_addr = 8'h04; reg_data = 8'h45; en = 1'b1;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      nxt = 1'b0;
      if (oe && dout == 8'h45) found = 1'b1;
      else if (oe) nxt = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_mis++;
      $display("FAIL rstmid_reach_data: data byte never driven, expected 45");
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (oe !== 1'b0 || stp !== 1'b0) begin
      n_mis++;
      $display("FAIL rstmid_bus: got oe=%b stp=%b, expected 0 0", oe, stp);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_mis++;
      $display("FAIL rstmid_busy: got busy=%b done=%b, expected 0 0", busy, done);
    end
    $display("reset mid-write: oe=%b stp=%b busy=%b", oe, stp, busy);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(9'h084); exp_q.push_back(9'h045); exp_q.push_back(9'h100);
    test_write("after_rst", 8'h04, 8'h45, 0, 0, 1'b0, 0, 2);
  endtask

  task automatic test_addr_forms;
`ifdef ULPI_EXT_REG_EN
    exp_q.push_back(9'h0AF); exp_q.push_back(9'h081);
    exp_q.push_back(9'h05A); exp_q.push_back(9'h100);
    test_write("ext81", 8'h81, 8'h5A, 0, 0, 1'b0, 0, 3);
    exp_q.push_back(9'h08A); exp_q.push_back(9'h05A); exp_q.push_back(9'h100);
    test_write("imm0a", 8'h0A, 8'h5A, 0, 0, 1'b0, 0, 2);
    exp_q.push_back(9'h0AF); exp_q.push_back(9'h02F);
    exp_q.push_back(9'h03C); exp_q.push_back(9'h100);
    test_write("ext2f", 8'h2F, 8'h3C, 0, 0, 1'b0, 0, 3);
`else
    exp_q.push_back(9'h0AF); exp_q.push_back(9'h03C); exp_q.push_back(9'h100);
    test_write("imm2f", 8'h2F, 8'h3C, 0, 0, 1'b0, 0, 2);
    exp_q.push_back(9'h0BF); exp_q.push_back(9'h0C3); exp_q.push_back(9'h100);
    test_write("imm3f", 8'h3F, 8'hC3, 1, 0, 1'b0, 0, 3);
`endif
  endtask

  task automatic test_back_to_back;
    exp_q.push_back(9'h081); exp_q.push_back(9'h011); exp_q.push_back(9'h100);
    test_write("b2b_a", 8'h01, 8'h11, 0, 0, 1'b0, 0, 2);
    exp_q.push_back(9'h092); exp_q.push_back(9'h0EE); exp_q.push_back(9'h100);
    test_write("b2b_b", 8'h12, 8'hEE, 2, 0, 1'b0, 0, 4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_timeout();
    test_reset_mid();
    test_addr_forms();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
